fft_bitrev_reorder: RTL



---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_bitrev_reorder_if.sv | 45 ++++
 rtl/fft_pingpong_ram.sv | 27 ++
 rtl/fft_bitrev_reorder.sv | 113 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output reorder stage.
// Optional marker outputs are enabled with FFT_REORDER_MARKERS_EN.
package fft_pkg;

   localparam int DATA_W = 16;
   localparam int N      = 256;
   localparam int LOG2N  = 8;

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] img;
   } cplx_t;

   typedef enum logic [0:0] {
      IDLE,
      READ
   } reorder_state_t;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = idx[LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle between the FFT core, the reorder stage and its sink.
// Marker signals exist only when FFT_REORDER_MARKERS_EN is defined.
interface fft_bitrev_reorder_if;
   import fft_pkg::*;

   logic                     in_valid;
   logic signed [DATA_W-1:0] in_yp_real;
   logic signed [DATA_W-1:0] in_yp_img;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_yp_real;
   logic signed [DATA_W-1:0] out_yp_img;
`ifdef FFT_REORDER_MARKERS_EN
   logic                     out_first;
   logic                     out_last;
`endif

   modport master (
      output in_valid,
      output in_yp_real,
      output in_yp_img,
      input  out_valid,
      input  out_yp_real,
      input  out_yp_img
`ifdef FFT_REORDER_MARKERS_EN
      ,
      input  out_first,
      input  out_last
`endif
   );

   modport slave (
      input  in_valid,
      input  in_yp_real,
      input  in_yp_img,
      output out_valid,
      output out_yp_real,
      output out_yp_img
`ifdef FFT_REORDER_MARKERS_EN
      ,
      output out_first,
      output out_last
`endif
   );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank complex sample store: one synchronous write port, one
// combinational read port, each with its own bank select.
module fft_pingpong_ram
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic             wbank,
   input  logic [LOG2N-1:0] waddr,
   input  cplx_t            wdata,
   input  logic             rbank,
   input  logic [LOG2N-1:0] raddr,
   output cplx_t            rdata
);

   cplx_t mem [2][N];

   // Contents are intentionally not reset; every slot is rewritten per frame.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wbank][waddr] <= wdata;
      end
   end

   assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder stage using a ping-pong buffer.
// Define FFT_REORDER_MARKERS_EN to add out_first/out_last markers.
module fft_bitrev_reorder
   import fft_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   fft_bitrev_reorder_if.slave  bus
);

   logic [LOG2N-1:0] wcnt;
   logic             wbank;
   logic [LOG2N-1:0] rcnt;
   logic             rbank;
   reorder_state_t   state;
   logic             frame_done;
   cplx_t            wdata;
   cplx_t            rdata;

   logic                     out_valid;
   logic signed [DATA_W-1:0] out_re;
   logic signed [DATA_W-1:0] out_img;

   assign frame_done = bus.in_valid && (wcnt == LAST_IDX);
   assign wdata      = '{re: bus.in_yp_real, img: bus.in_yp_img};

   fft_pingpong_ram u_ram (
      .clk   (clk),
      .we    (bus.in_valid),
      .wbank (wbank),
      .waddr (bitrev(wcnt)),
      .wdata (wdata),
      .rbank (rbank),
      .raddr (rcnt),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt  <= '0;
         wbank <= 1'b0;
      end else if (bus.in_valid) begin
         wcnt <= wcnt + 1'b1;
         if (wcnt == LAST_IDX) begin
            wbank <= ~wbank;
         end
      end
   end

`ifdef FFT_REORDER_MARKERS_EN
   logic out_first;
   logic out_last;
`endif

   // The completed bank is the one being written when frame_done fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rcnt      <= '0;
         rbank     <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_img   <= '0;
`ifdef FFT_REORDER_MARKERS_EN
         out_first <= 1'b0;
         out_last  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               out_valid <= 1'b0;
               out_re    <= '0;
               out_img   <= '0;
`ifdef FFT_REORDER_MARKERS_EN
               out_first <= 1'b0;
               out_last  <= 1'b0;
`endif
               if (frame_done) begin
                  rbank <= wbank;
                  rcnt  <= '0;
                  state <= READ;
               end
            end
            READ: begin
               out_valid <= 1'b1;
               out_re    <= rdata.re;
               out_img   <= rdata.img;
`ifdef FFT_REORDER_MARKERS_EN
               out_first <= (rcnt == '0);
               out_last  <= (rcnt == LAST_IDX);
`endif
               rcnt <= rcnt + 1'b1;
               if (rcnt == LAST_IDX) begin
                  if (frame_done) begin
                     rbank <= wbank;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign bus.out_valid   = out_valid;
   assign bus.out_yp_real = out_re;
   assign bus.out_yp_img  = out_img;
`ifdef FFT_REORDER_MARKERS_EN
   assign bus.out_first   = out_first;
   assign bus.out_last    = out_last;
`endif

endmodule
